// File: rtl/fpu_fp32_to_fp64.sv
// Purpose : widen an IEEE-754 FP32 operand to FP64. Denormal inputs are
//           normalised one bit per cycle.
// Latency : result valid the cycle after accept for normals, zeros, infinities
//           and NaNs. Denormals take k extra edges, where k = 23 - msb_index(f).
// Backpr. : single entry. in_ready is low from accept until the output
//           handshake, and dst/out_snan are held while out_ready=0.
// Ports   : clk, reset_n (async active-low)
//           in_valid/in_ready/src[31:0]   : FP32 operand handshake
//           out_valid/out_ready/dst[63:0] : FP64 result handshake
//           out_snan                      : source was a signalling NaN (with out_valid)
module fpu_fp32_to_fp64 #(
    parameter int EXP_BIAS_DIFF = 896
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] dst,
    output logic        out_snan
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NORM = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [10:0] BIAS_DIFF = 11'(EXP_BIAS_DIFF);
    // A denormal with an implicit leading bit at index 23 would carry exponent
    // 897. Each normalising shift lowers it by one.
    localparam logic [10:0] DENORM_EXP0 = 11'(EXP_BIAS_DIFF + 1);

    logic [1:0]  state_q, state_d;
    logic [63:0] dst_q, dst_d;
    logic        snan_q, snan_d;
    logic [23:0] m_q, m_d;
    logic [10:0] exp_q, exp_d;
    logic        sign_q, sign_d;

    logic        src_s;
    logic [7:0]  src_e;
    logic [22:0] src_f;
    logic [23:0] m_shift;
    logic [10:0] exp_dec;

    assign src_s   = src[31];
    assign src_e   = src[30:23];
    assign src_f   = src[22:0];
    assign m_shift = m_q << 1;
    assign exp_dec = exp_q - 11'd1;

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        snan_d  = snan_q;
        m_d     = m_q;
        exp_d   = exp_q;
        sign_d  = sign_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = src_s;
                    snan_d  = 1'b0;
                    state_d = ST_DONE;
                    if (src_e == 8'h00 && src_f == 23'd0) begin
                        dst_d = {src_s, 63'd0};
                    end else if (src_e == 8'hFF && src_f == 23'd0) begin
                        dst_d = {src_s, 11'h7FF, 52'd0};
                    end else if (src_e == 8'hFF) begin
                        // Quiet bit forced, payload kept in the upper fraction bits.
                        dst_d  = {src_s, 11'h7FF, 1'b1, src_f[21:0], 29'd0};
                        snan_d = ~src_f[22];
                    end else if (src_e != 8'h00) begin
                        dst_d = {src_s, {3'd0, src_e} + BIAS_DIFF, src_f, 29'd0};
                    end else begin
                        m_d     = {1'b0, src_f};
                        exp_d   = DENORM_EXP0;
                        state_d = ST_NORM;
                    end
                end
            end

            ST_NORM: begin
                m_d   = m_shift;
                exp_d = exp_dec;
                // The shifted-in leading one becomes the hidden bit.
                if (m_shift[23]) begin
                    dst_d   = {sign_q, exp_dec, m_shift[22:0], 29'd0};
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            dst_q   <= 64'd0;
            snan_q  <= 1'b0;
            m_q     <= 24'd0;
            exp_q   <= 11'd0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            snan_q  <= snan_d;
            m_q     <= m_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
        end
    end

    // Handshake outputs are decoded from the state register alone.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign dst       = dst_q;
    assign out_snan  = snan_q;

endmodule

// File: tb/tb_fpu_fp32_to_fp64.sv
module tb_fpu_fp32_to_fp64;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dst;
    logic        out_snan;

    fpu_fp32_to_fp64 dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .src      (src),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dst      (dst),
        .out_snan (out_snan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] dst;
        logic        snan;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Monitor: pops an expected result at every output handshake.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got dst=%h with no expected entry", dst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_dst", dst, e.dst);
                chk("sb_snan", {63'd0, out_snan}, {63'd0, e.snan});
            end
        end
    end

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1");
        end
    endtask

    // Issues one operand, checks latency, optional backpressure hold, and return to idle.
    task automatic convert(input logic [31:0] v, input logic [63:0] want_dst,
                           input logic want_snan, input int want_lat, input int hold);
        int   lat;
        exp_t e;
        wait_in_ready();
        if (hold > 0) out_ready = 1'b0;
        src      = v;
        in_valid = 1'b1;
        e.dst  = want_dst;
        e.snan = want_snan;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        src      = 32'hDEADBEEF;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(want_lat));
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_dst", dst, want_dst);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        src       = 32'd0;
        #2;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_dst", dst, 64'd0);
        chk("rst_snan", {63'd0, out_snan}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        convert(32'h3F800000, 64'h3FF0000000000000, 1'b0, 0, 0);
        convert(32'h80000000, 64'h8000000000000000, 1'b0, 0, 0);
        convert(32'hFF800000, 64'hFFF0000000000000, 1'b0, 0, 0);
        convert(32'h7F800001, 64'h7FF8000020000000, 1'b1, 0, 0);
        convert(32'h7FC00000, 64'h7FF8000000000000, 1'b0, 0, 0);
        convert(32'h00000001, 64'h36A0000000000000, 1'b0, 23, 0);
        convert(32'h00400000, 64'h3800000000000000, 1'b0, 1, 0);
        convert(32'h00000003, 64'h36B8000000000000, 1'b0, 22, 0);
        convert(32'h80400000, 64'hB800000000000000, 1'b0, 1, 0);
        convert(32'h3F800000, 64'h3FF0000000000000, 1'b0, 0, 5);

        // Reset asserted asynchronously while normalising a denormal.
        wait_in_ready();
        src      = 32'h00000001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_dst", dst, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        convert(32'h40490FDB, 64'h400921FB60000000, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_fp32_to_fp64.md
Name: fpu_fp32_to_fp64

Overview:
- Widening converter: IEEE-754 single-precision (FP32) to double-precision (FP64). It is the companion of the FPU's FP64-to-FP32 narrowing path and is used for FLDS/FCNVSD-style operations.
- Single-entry, multi-cycle unit with valid/ready handshakes on both sides.
- Normal values, zeros, infinities and NaNs convert in one cycle.
- FP32 denormals are normalised iteratively, one bit per cycle, because FP64 represents them as normal numbers.

Parameters:
- EXP_BIAS_DIFF, 896, added to the FP32 exponent for normal inputs (1023-127).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  src is valid
- in_ready  out  1  unit can accept src
- src  in  32  FP32 operand
- out_valid  out  1  dst is valid
- out_ready  in  1  consumer accepts dst
- dst  out  64  FP64 result
- out_snan  out  1  input was a signalling NaN; qualified by out_valid

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE, in_ready=1, out_valid=0, dst=0, out_snan=0, internal mantissa/counter=0.
- Reset mid-operation abandons the conversion with no output.
- Fields: s=src[31], e=src[30:23], f=src[22:0].
- States:
  - IDLE: in_ready=1, out_valid=0.
  - NORM: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept occurs on the edge where in_valid && in_ready.
- Classification at accept:
  - e=0, f=0: dst={s,63'b0}; go to DONE.
  - e=FF, f=0: dst={s,11'h7FF,52'b0}; go to DONE.
  - e=FF, f!=0: dst={s,11'h7FF,1'b1,f[21:0],29'b0}. Quiet bit is forced and the payload kept. out_snan=~f[22]. Go to DONE.
  - e in 1..FE: dst={s, e+EXP_BIAS_DIFF (11 bits, zero-extended add), f, 29'b0}; go to DONE.
  - e=0, f!=0 (denormal): load m[23:0]={1'b0,f}, exp11=897; go to NORM.
- NORM, each edge: m<=m<<1 and exp11<=exp11-1.
  - If the shifted m[23]=1: dst={s, exp11-1, shifted m[22:0], 29'b0}; go to DONE.
  - The number of NORM edges is k=23-p, where p is the index of the MSB of f (k ranges 1..23).
  - Final exponent = 897-k, which ranges 874..896. No underflow is possible.
- out_snan=0 for all non-NaN results.
- Latency, counted in rising edges after the accept edge at which out_valid is first high:
  - 0 for non-denormals (out_valid is high in the cycle right after the accept edge).
  - k for denormals, i.e. total k+1 cycles accept-to-result.
- DONE: dst and out_snan are held stable while out_ready=0. On out_valid && out_ready, go to IDLE with out_valid=0. dst keeps its last value.
- No bypass: a new input cannot be accepted in the same cycle as the output handshake. Throughput is at most one conversion per 2 cycles.
- src is sampled only on the accept edge. Changes to src afterwards have no effect.
- All outputs are registered. There are no combinational paths from inputs to outputs except none: in_ready and out_valid depend on state only.

Test Plan:
- src=3F800000 (1.0), out_ready=1 -> dst=3FF0000000000000 one cycle after accept, out_snan=0, in_ready returns high next cycle.
- src=80000000 -> dst=8000000000000000. src=FF800000 -> dst=FFF0000000000000. Both complete in 1 cycle.
- src=7F800001 (sNaN) -> dst=7FF8000020000000, out_snan=1. src=7FC00000 (qNaN) -> dst=7FF8000000000000, out_snan=0.
- Denormals:
  - src=00000001 -> 23 NORM cycles, dst=36A0000000000000 (24 cycles accept-to-valid).
  - src=00400000 -> 1 NORM cycle, dst=3800000000000000.
- Backpressure: after 3F800000 completes, hold out_ready=0 for 5 cycles -> dst and out_valid stable and in_ready=0. Then out_ready=1 -> handshake, then IDLE.
- Assert reset_n=0 asynchronously during NORM of 00000001 -> out_valid=0, in_ready=1 and dst=0 immediately. After release, src=40490FDB converts to 400921FB60000000.
